ram_82s21_ctl: RTL and testbench

- Initiator/sequencer for the 32x2 write-while-read bipolar RAM (82S21 pinout).
- Converts a synchronous valid/ready request port into correctly ordered and timed pin sequences: CE, address, STROBE, data-in, WE0_N/WE1_N and WCLK_N.
- Captures read data from the RAM outputs.
- Used by datapath blocks (dispatch/stack-style scratch stores) that need read, write, or atomic read-old/write-new (swap) access to one 82S21.

---
 rtl/ram82s21_pkg.sv | 24 ++
 rtl/ram82s21_phase_timer.sv | 40 ++++
 rtl/ram_82s21_ctl.sv | 186 ++++++++++++++++++
 tb/tb_ram_82s21_ctl.sv | 310 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ram82s21_pkg.sv
// Shared definitions for the 82S21 (32x2 write-while-read RAM) controller.
//   op encodings, FSM state type and the phase-counter width.
package ram82s21_pkg;

   localparam int unsigned CNT_W  = 4;
   localparam int unsigned ADDR_W = 5;
   localparam int unsigned DATA_W = 2;

   localparam logic [1:0] OP_READ  = 2'b00;
   localparam logic [1:0] OP_WRITE = 2'b01;
   localparam logic [1:0] OP_SWAP  = 2'b10;
   localparam logic [1:0] OP_NOP   = 2'b11;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_SETUP  = 3'd1,
      ST_STROBE = 3'd2,
      ST_SAMPLE = 3'd3,
      ST_WPULSE = 3'd4,
      ST_HOLD   = 3'd5,
      ST_RESP   = 3'd6
   } state_e;

endpackage

// File: rtl/ram82s21_phase_timer.sv
// Phase duration timer: loads N-1 on entry to a timed phase, counts down,
// and flags the last cycle of the phase.
//   clk, reset_n  : clock, async active-low reset
//   load_i        : load load_val_i this edge (phase entry)
//   load_val_i    : phase length minus one
//   tc_c          : combinational terminal count (current cycle is the last)
module ram82s21_phase_timer
   import ram82s21_pkg::*;
(
   input  logic             clk,
   input  logic             reset_n,
   input  logic             load_i,
   input  logic [CNT_W-1:0] load_val_i,
   output logic             tc_c
);

   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;

   // Load has priority; otherwise count down and park at zero.
   always_comb begin
      cnt_d = cnt_q;
      if (load_i) begin
         cnt_d = load_val_i;
      end else if (cnt_q != '0) begin
         cnt_d = cnt_q - CNT_W'(1);
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign tc_c = (cnt_q == '0);

endmodule

// File: rtl/ram_82s21_ctl.sv
// Request sequencer for one 82S21 32x2 write-while-read RAM.
// Turns valid/ready read/write/swap/no-op requests into timed CE, address,
// STROBE, data-in and write-enable/write-clock pin sequences, and returns
// read data with a one-cycle rsp_valid pulse. All outputs are registered.
//   clk, reset_n              : clock, async active-low reset
//   req_valid/req_ready       : request handshake (accept on both high)
//   req_op/req_addr/req_wdata : operation, word address, write data
//   rsp_valid/rsp_data        : completion pulse, read data
//   ram_a/ram_i/ram_ce        : address, data-in, chip enable
//   ram_strobe                : read strobe (RAM latches on falling edge)
//   ram_we0_n/ram_we1_n/ram_wclk_n : active-low write enables and clock
//   ram_d                     : RAM data outputs
module ram_82s21_ctl
   import ram82s21_pkg::*;
#(
   parameter int unsigned SETUP_CYC  = 1,
   parameter int unsigned STROBE_CYC = 2,
   parameter int unsigned WE_CYC     = 2,
   parameter int unsigned HOLD_CYC   = 1
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic [1:0]        req_op,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [DATA_W-1:0] req_wdata,
   output logic              rsp_valid,
   output logic [DATA_W-1:0] rsp_data,
   output logic [ADDR_W-1:0] ram_a,
   output logic [DATA_W-1:0] ram_i,
   output logic              ram_ce,
   output logic              ram_strobe,
   output logic              ram_we0_n,
   output logic              ram_we1_n,
   output logic              ram_wclk_n,
   input  logic [DATA_W-1:0] ram_d
);

   state_e            state_q, state_d;
   logic [1:0]        op_q, op_d;
   logic [ADDR_W-1:0] a_q, a_d;
   logic [DATA_W-1:0] i_q, i_d;
   logic [DATA_W-1:0] rsp_data_q, rsp_data_d;
   logic              req_ready_q, req_ready_d;
   logic              rsp_valid_q, rsp_valid_d;
   logic              ce_q, ce_d;
   logic              strobe_q, strobe_d;
   logic              we_n_q, we_n_d;

   logic              accept_c;
   logic              tmr_load_c;
   logic [CNT_W-1:0]  tmr_val_c;
   logic              tmr_tc_c;

   ram82s21_phase_timer u_timer (
      .clk        (clk),
      .reset_n    (reset_n),
      .load_i     (tmr_load_c),
      .load_val_i (tmr_val_c),
      .tc_c       (tmr_tc_c)
   );

   // Next state, captured request fields and next values of every output.
   // Outputs are decoded from the next state so the pins change on the same
   // edge as the state register.
   always_comb begin
      state_d    = state_q;
      op_d       = op_q;
      a_d        = a_q;
      i_d        = i_q;
      rsp_data_d = rsp_data_q;
      tmr_load_c = 1'b0;
      tmr_val_c  = '0;
      accept_c   = req_valid & req_ready_q;

      case (state_q)
         ST_IDLE: begin
            if (accept_c) begin
               op_d = req_op;
               if (req_op == OP_NOP) begin
                  state_d = ST_RESP;
               end else begin
                  state_d = ST_SETUP;
                  a_d     = req_addr;
                  i_d     = req_wdata;
               end
            end
         end
         ST_SETUP: begin
            if (tmr_tc_c) begin
               state_d = (op_q == OP_WRITE) ? ST_WPULSE : ST_STROBE;
            end
         end
         ST_STROBE: begin
            if (tmr_tc_c) begin
               state_d = ST_SAMPLE;
            end
         end
         ST_SAMPLE: begin
            // Strobe has just fallen; the RAM output is latched and stable.
            rsp_data_d = ram_d;
            state_d    = (op_q == OP_READ) ? ST_RESP : ST_WPULSE;
         end
         ST_WPULSE: begin
            if (tmr_tc_c) begin
               state_d = ST_HOLD;
            end
         end
         ST_HOLD: begin
            if (tmr_tc_c) begin
               state_d = ST_RESP;
            end
         end
         ST_RESP: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      // Every timed phase differs from its predecessor, so a state change
      // is exactly a phase entry.
      if (state_d != state_q) begin
         tmr_load_c = 1'b1;
         case (state_d)
            ST_SETUP:  tmr_val_c = CNT_W'(SETUP_CYC - 1);
            ST_STROBE: tmr_val_c = CNT_W'(STROBE_CYC - 1);
            ST_WPULSE: tmr_val_c = CNT_W'(WE_CYC - 1);
            ST_HOLD:   tmr_val_c = CNT_W'(HOLD_CYC - 1);
            default:   tmr_val_c = '0;
         endcase
      end

      // Ops that read nothing report zero data.
      if ((state_d == ST_RESP) && ((op_d == OP_WRITE) || (op_d == OP_NOP))) begin
         rsp_data_d = '0;
      end

      req_ready_d = (state_d == ST_IDLE);
      rsp_valid_d = (state_d == ST_RESP);
      ce_d        = (state_d inside {ST_SETUP, ST_STROBE, ST_SAMPLE, ST_WPULSE, ST_HOLD});
      strobe_d    = (state_d == ST_STROBE);
      we_n_d      = (state_d != ST_WPULSE);
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= ST_IDLE;
         op_q        <= OP_READ;
         a_q         <= '0;
         i_q         <= '0;
         rsp_data_q  <= '0;
         req_ready_q <= 1'b0;
         rsp_valid_q <= 1'b0;
         ce_q        <= 1'b0;
         strobe_q    <= 1'b0;
         we_n_q      <= 1'b1;
      end else begin
         state_q     <= state_d;
         op_q        <= op_d;
         a_q         <= a_d;
         i_q         <= i_d;
         rsp_data_q  <= rsp_data_d;
         req_ready_q <= req_ready_d;
         rsp_valid_q <= rsp_valid_d;
         ce_q        <= ce_d;
         strobe_q    <= strobe_d;
         we_n_q      <= we_n_d;
      end
   end

   assign req_ready  = req_ready_q;
   assign rsp_valid  = rsp_valid_q;
   assign rsp_data   = rsp_data_q;
   assign ram_a      = a_q;
   assign ram_i      = i_q;
   assign ram_ce     = ce_q;
   assign ram_strobe = strobe_q;
   // Both write enables and the write clock share one pulse.
   assign ram_we0_n  = we_n_q;
   assign ram_we1_n  = we_n_q;
   assign ram_wclk_n = we_n_q;

endmodule

// File: tb/tb_ram_82s21_ctl.sv
// Bench for ram_82s21_ctl: a default-timing instance (a) and a slow-timing
// instance (b), each driving its own behavioural 82S21 model.
module tb_ram_82s21_ctl;
   import ram82s21_pkg::*;

   localparam int P_S  [2] = '{1, 3};
   localparam int P_ST [2] = '{2, 1};
   localparam int P_WE [2] = '{4 - 2, 4};
   localparam int P_H  [2] = '{1, 2};

   logic clk = 1'b0;
   logic reset_n;
   always #5 clk = ~clk;

   logic       req_valid [2];
   logic [1:0] req_op    [2];
   logic [4:0] req_addr  [2];
   logic [1:0] req_wdata [2];
   logic [1:0] ram_d     [2];

   logic       a_req_ready, a_rsp_valid, a_ram_ce, a_ram_strobe, a_we0_n, a_we1_n, a_wclk_n;
   logic [1:0] a_rsp_data, a_ram_i;
   logic [4:0] a_ram_a;
   logic       b_req_ready, b_rsp_valid, b_ram_ce, b_ram_strobe, b_we0_n, b_we1_n, b_wclk_n;
   logic [1:0] b_rsp_data, b_ram_i;
   logic [4:0] b_ram_a;

   ram_82s21_ctl dut_a (
      .clk(clk), .reset_n(reset_n),
      .req_valid(req_valid[0]), .req_ready(a_req_ready), .req_op(req_op[0]),
      .req_addr(req_addr[0]), .req_wdata(req_wdata[0]),
      .rsp_valid(a_rsp_valid), .rsp_data(a_rsp_data),
      .ram_a(a_ram_a), .ram_i(a_ram_i), .ram_ce(a_ram_ce), .ram_strobe(a_ram_strobe),
      .ram_we0_n(a_we0_n), .ram_we1_n(a_we1_n), .ram_wclk_n(a_wclk_n), .ram_d(ram_d[0])
   );

   ram_82s21_ctl #(.SETUP_CYC(3), .STROBE_CYC(1), .WE_CYC(4), .HOLD_CYC(2)) dut_b (
      .clk(clk), .reset_n(reset_n),
      .req_valid(req_valid[1]), .req_ready(b_req_ready), .req_op(req_op[1]),
      .req_addr(req_addr[1]), .req_wdata(req_wdata[1]),
      .rsp_valid(b_rsp_valid), .rsp_data(b_rsp_data),
      .ram_a(b_ram_a), .ram_i(b_ram_i), .ram_ce(b_ram_ce), .ram_strobe(b_ram_strobe),
      .ram_we0_n(b_we0_n), .ram_we1_n(b_we1_n), .ram_wclk_n(b_wclk_n), .ram_d(ram_d[1])
   );

   wire [1:0]      ready_v = {b_req_ready, a_req_ready};
   wire [1:0]      rv_v    = {b_rsp_valid, a_rsp_valid};
   wire [1:0][1:0] rdata_v = {b_rsp_data, a_rsp_data};
   wire [1:0][4:0] addr_v  = {b_ram_a, a_ram_a};
   wire [1:0][1:0] i_v     = {b_ram_i, a_ram_i};
   wire [1:0]      ce_v    = {b_ram_ce, a_ram_ce};
   wire [1:0]      st_v    = {b_ram_strobe, a_ram_strobe};
   wire [1:0]      we0n_v  = {b_we0_n, a_we0_n};
   wire [1:0]      we1n_v  = {b_we1_n, a_we1_n};
   wire [1:0]      wclkn_v = {b_wclk_n, a_wclk_n};
   wire [1:0]      we_v    = ~we0n_v;

   // RAM model and pin monitor, sampled on the falling clock edge.
   logic [1:0] mem [2][32];
   logic [4:0] a_prev [2];
   logic [1:0] i_prev [2];
   bit         pulsed [2];
   int ce_cnt[2], ce_tot[2], st_run[2], we_run[2], st_w[2], we_w[2];
   int st_n[2], we_n[2], setup_w[2], viol[2], rsp_n[2];

   always @(negedge clk) begin
      for (int d = 0; d < 2; d++) begin
         ce_cnt[d] <= ce_v[d] ? ce_cnt[d] + 1 : 0;
         ce_tot[d] <= ce_tot[d] + int'(ce_v[d]);
         pulsed[d] <= ce_v[d] ? (pulsed[d] | st_v[d] | we_v[d]) : 1'b0;
         if ((st_v[d] | we_v[d]) && !pulsed[d]) setup_w[d] <= ce_cnt[d];
         st_run[d] <= st_v[d] ? st_run[d] + 1 : 0;
         if (!st_v[d] && st_run[d] != 0) begin
            st_w[d] <= st_run[d];
            st_n[d] <= st_n[d] + 1;
         end
         we_run[d] <= we_v[d] ? we_run[d] + 1 : 0;
         if (!we_v[d] && we_run[d] != 0) begin
            we_w[d] <= we_run[d];
            we_n[d] <= we_n[d] + 1;
         end
         viol[d] <= viol[d] + int'(st_v[d] & we_v[d])
                  + int'((we0n_v[d] != we1n_v[d]) || (we0n_v[d] != wclkn_v[d]))
                  + int'(ce_v[d] && ce_cnt[d] != 0 && (addr_v[d] != a_prev[d] || i_v[d] != i_prev[d]))
                  + int'((st_v[d] | we_v[d]) & ~ce_v[d]);
         a_prev[d] <= addr_v[d];
         i_prev[d] <= i_v[d];
         rsp_n[d]  <= rsp_n[d] + int'(rv_v[d]);
         if (we_v[d]) mem[d][addr_v[d]] <= i_v[d];
         if (st_v[d]) ram_d[d] <= mem[d][addr_v[d]];
      end
   end

   int checks = 0;
   int failures = 0;
   int nops [2] = '{0, 0};
   logic [1:0] ref_mem [2][32];

   typedef struct {
      int         d;
      logic [1:0] op;
      logic [4:0] addr;
      logic [1:0] wd;
      int         lat;
      logic [1:0] data;
   } vec_t;
   vec_t tbl [9];

   task automatic chk(input string tag, input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s %s actual=%0d required=%0d", tag, name, act, exp);
      end
   endtask

   function automatic int lat_model(input int d, input logic [1:0] op);
      case (op)
         OP_READ:  return P_S[d] + P_ST[d] + 2;
         OP_WRITE: return P_S[d] + P_WE[d] + P_H[d] + 1;
         OP_SWAP:  return P_S[d] + P_ST[d] + P_WE[d] + P_H[d] + 2;
         default:  return 1;
      endcase
   endfunction

   task automatic chk_inactive(input int d, input string tag, input int exp_ready);
      chk(tag, "ram_ce", int'(ce_v[d]), 0);
      chk(tag, "ram_strobe", int'(st_v[d]), 0);
      chk(tag, "ram_we0_n", int'(we0n_v[d]), 1);
      chk(tag, "ram_we1_n", int'(we1n_v[d]), 1);
      chk(tag, "ram_wclk_n", int'(wclkn_v[d]), 1);
      chk(tag, "rsp_valid", int'(rv_v[d]), 0);
      chk(tag, "req_ready", int'(ready_v[d]), exp_ready);
   endtask

   // Present one request, wait (bounded) for acceptance and the response.
   task automatic do_op(input int d, input logic [1:0] op, input logic [4:0] addr,
                        input logic [1:0] wd, input bit keep,
                        output int lat, output int data, output int gap);
      req_valid[d] = 1'b1;
      req_op[d]    = op;
      req_addr[d]  = addr;
      req_wdata[d] = wd;
      gap = 0;
      lat = -1;
      data = -1;
      while (!ready_v[d] && gap < 50) begin
         @(negedge clk);
         gap++;
      end
      if (!ready_v[d]) begin
         chk("accept", "timeout", 0, 1);
         req_valid[d] = 1'b0;
         return;
      end
      @(posedge clk);
      #1;
      if (!keep) req_valid[d] = 1'b0;
      // Captured fields must be immune to later request-port changes.
      req_op[d]    = 2'($urandom);
      req_addr[d]  = 5'($urandom);
      req_wdata[d] = 2'($urandom);
      lat = 0;
      do begin
         @(negedge clk);
         lat++;
      end while (!rv_v[d] && lat < 40);
      data = int'(rdata_v[d]);
   endtask

   task automatic run_op(input int d, input logic [1:0] op, input logic [4:0] addr,
                         input logic [1:0] wd, input bit keep,
                         input int exp_lat, input int exp_data, output int gap);
      int sn, wn, cn, lat, data;
      string tag;
      bit rd, wr;
      rd = (op == OP_READ) || (op == OP_SWAP);
      wr = (op == OP_WRITE) || (op == OP_SWAP);
      sn = st_n[d];
      wn = we_n[d];
      cn = ce_tot[d];
      tag = $sformatf("dut%0d op%0d addr%0d", d, op, addr);
      do_op(d, op, addr, wd, keep, lat, data, gap);
      nops[d]++;
      chk(tag, "latency", lat, exp_lat);
      chk(tag, "rsp_data", data, exp_data);
      chk(tag, "strobe_pulses", st_n[d] - sn, int'(rd));
      chk(tag, "we_pulses", we_n[d] - wn, int'(wr));
      if (rd) chk(tag, "strobe_width", st_w[d], P_ST[d]);
      if (wr) chk(tag, "we_width", we_w[d], P_WE[d]);
      if (op != OP_NOP) chk(tag, "setup_width", setup_w[d], P_S[d]);
      chk(tag, "ce_cycles", ce_tot[d] - cn, (op == OP_NOP) ? 0 : lat_model(d, op) - 1);
      if (wr) ref_mem[d][addr] = wd;
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      int gap, w, rn, d, expd;
      logic [1:0] op, wd;
      logic [4:0] addr;

      tbl[0] = '{0, OP_WRITE,  5, 2'b10,  5, 2'b00};
      tbl[1] = '{0, OP_READ,   5, 2'b00,  5, 2'b10};
      tbl[2] = '{0, OP_WRITE, 31, 2'b01,  5, 2'b00};
      tbl[3] = '{0, OP_SWAP,  31, 2'b11,  8, 2'b01};
      tbl[4] = '{0, OP_READ,  31, 2'b00,  5, 2'b11};
      tbl[5] = '{0, OP_NOP,    7, 2'b01,  1, 2'b00};
      tbl[6] = '{1, OP_WRITE,  9, 2'b11, 10, 2'b00};
      tbl[7] = '{1, OP_READ,   9, 2'b00,  6, 2'b11};
      tbl[8] = '{1, OP_NOP,    3, 2'b10,  1, 2'b00};

      reset_n = 1'b0;
      for (int k = 0; k < 2; k++) begin
         req_valid[k] = 1'b0;
         req_op[k]    = 2'b00;
         req_addr[k]  = 5'd0;
         req_wdata[k] = 2'b00;
      end
      repeat (3) @(negedge clk);
      for (int k = 0; k < 2; k++) begin
         chk_inactive(k, "reset", 0);
         chk("reset", "rsp_data", int'(rdata_v[k]), 0);
         chk("reset", "ram_a", int'(addr_v[k]), 0);
         chk("reset", "ram_i", int'(i_v[k]), 0);
      end
      reset_n = 1'b1;
      @(negedge clk);
      chk("release", "req_ready_a", int'(ready_v[0]), 1);
      chk("release", "req_ready_b", int'(ready_v[1]), 1);

      // Directed vectors.
      for (int k = 0; k < 9; k++) begin
         run_op(tbl[k].d, tbl[k].op, tbl[k].addr, tbl[k].wd, 1'b0,
                tbl[k].lat, int'(tbl[k].data), gap);
      end

      // Give every word a known value.
      for (int k = 0; k < 2; k++) begin
         for (int a = 0; a < 32; a++) begin
            run_op(k, OP_WRITE, 5'(a), 2'($urandom), 1'b0, lat_model(k, OP_WRITE), 0, gap);
         end
      end

      // Back-to-back with req_valid held high: one idle cycle between ops.
      for (int k = 0; k < 4; k++) begin
         op   = (k % 2 == 0) ? OP_WRITE : OP_READ;
         addr = 5'(k);
         wd   = 2'($urandom);
         expd = (op == OP_READ) ? int'(ref_mem[0][addr]) : 0;
         run_op(0, op, addr, wd, 1'b1, lat_model(0, op), expd, gap);
         if (k > 0) chk("b2b", "idle_gap", gap, 1);
      end
      req_valid[0] = 1'b0;

      // Randomized ops against the reference model.
      for (int k = 0; k < 40; k++) begin
         d    = int'($urandom_range(1, 0));
         op   = 2'($urandom);
         addr = 5'($urandom);
         wd   = 2'($urandom);
         expd = (op == OP_READ || op == OP_SWAP) ? int'(ref_mem[d][addr]) : 0;
         run_op(d, op, addr, wd, 1'b0, lat_model(d, op), expd, gap);
      end

      // Reset during the strobe of a read.
      rn = rsp_n[0];
      req_valid[0] = 1'b1;
      req_op[0]    = OP_READ;
      req_addr[0]  = 5'd5;
      w = 0;
      while (!ready_v[0] && w < 50) begin
         @(negedge clk);
         w++;
      end
      @(posedge clk);
      #1 req_valid[0] = 1'b0;
      w = 0;
      do begin
         @(negedge clk);
         w++;
      end while (!st_v[0] && w < 20);
      chk("abort", "strobe_seen", int'(st_v[0]), 1);
      #2 reset_n = 1'b0;
      #1;
      chk_inactive(0, "abort", 0);
      chk("abort", "ram_a", int'(addr_v[0]), 0);
      @(negedge clk);
      @(negedge clk);
      reset_n = 1'b1;
      repeat (12) @(negedge clk);
      chk("abort", "rsp_after_release", rsp_n[0] - rn, 0);
      chk("abort", "req_ready", int'(ready_v[0]), 1);
      run_op(0, OP_READ, 5'd31, 2'b00, 1'b0, lat_model(0, OP_READ), int'(ref_mem[0][31]), gap);

      repeat (3) @(negedge clk);
      for (int k = 0; k < 2; k++) begin
         chk("final", "pin_rule_violations", viol[k], 0);
         chk("final", "rsp_count", rsp_n[k], nops[k]);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
